// File: rtl/sin_nco_rd.sv
// ============================================================================
// Module   : sin_nco_rd
// Purpose  : Phase-accumulator NCO issuing reads to a registered sine ROM,
//            with a 2-entry output FIFO and ready/valid handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sin_nco_rd #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int PW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          phase_clr,
  input  logic [PW-1:0] freq_word,
  output logic          rom_ce_n,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [PW-1:0] r_phase;
  logic          r_inflight;
  logic [DW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;

  logic          w_pop;
  logic          w_push;
  logic [2:0]    w_occ;
  logic          w_issue;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rptr];
  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_inflight;

  // Occupancy counts the read in flight so a new read is only issued when a
  // FIFO slot is guaranteed for its data; this is what rules out overflow.
  // pop implies count >= 1, so the subtraction never underflows.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = rst_n & en & ~phase_clr & (w_occ < 3'd2);

  assign rom_ce_n = ~w_issue;
  assign rom_addr = r_phase[PW-1 -: AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (phase_clr) begin
        r_phase <= '0;
      end else if (w_issue) begin
        r_phase <= r_phase + freq_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= rom_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) r_count <= 2'd2);

endmodule

`default_nettype wire

// File: tb/tb_sin_nco_rd.sv
// ============================================================================
// Module   : tb_sin_nco_rd
// Purpose  : Directed self-checking bench for sin_nco_rd with a registered ROM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sin_nco_rd;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int PW = 24;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          phase_clr;
  logic [PW-1:0] freq_word;
  logic          rom_ce_n;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  int total;
  int bad;

  sin_nco_rd #(.DW(DW), .AW(AW), .PW(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .phase_clr (phase_clr),
    .freq_word (freq_word),
    .rom_ce_n  (rom_ce_n),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM with mem[i] = 0x1000 + i and one registered address stage
  always_ff @(posedge clk) begin
    if (!rom_ce_n) rom_data <= 16'h1000 + {8'h00, rom_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] smp(input int addr);
    logic [7:0] a;
    a = addr[7:0];
    return {1'b1, 8'h10, a};
  endfunction

  initial begin
    int idx;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    phase_clr = 1'b0;
    freq_word = 24'h010000;
    out_ready = 1'b1;
    #1;
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ce_n",  {31'd0, rom_ce_n},  32'd1);
    chk("rst_addr",  {24'd0, rom_addr},  32'd0);
    chk("rst_data",  {16'd0, out_data},  32'd0);

    // release with en low: nothing may issue
    en = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    step();
    chk("idle_ce_n",  {31'd0, rom_ce_n},  32'd1);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // count-up: first sample after two edges, then one per cycle across wrap
    en = 1'b1;
    #1;
    chk("cu_ce_n", {31'd0, rom_ce_n}, 32'd0);
    chk("cu_addr", {24'd0, rom_addr}, 32'd0);
    step();
    chk("cu_lat_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 260; i++) begin
      step();
      chk("cu_stream", {15'd0, out_valid, out_data}, {15'd0, smp(i)});
    end
    idx = 259;

    // backpressure: at most two buffered, ROM idle, head stable
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("bp_head", {15'd0, out_valid, out_data}, {15'd0, smp(idx)});
      chk("bp_ce_n", {31'd0, rom_ce_n}, 32'd1);
      if (i < 5) step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ce_n", {31'd0, rom_ce_n}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      idx++;
      chk("bp_resume", {15'd0, out_valid, out_data}, {15'd0, smp(idx)});
    end

    // en drop for one cycle, then clear: in-flight sample still delivered
    en = 1'b0;
    #1;
    chk("drop_ce_n", {31'd0, rom_ce_n}, 32'd1);
    step();
    idx++;
    chk("drop_inflight", {15'd0, out_valid, out_data}, {15'd0, smp(idx)});
    en        = 1'b1;
    phase_clr = 1'b1;
    #1;
    chk("clr_ce_n", {31'd0, rom_ce_n}, 32'd1);
    step();
    chk("clr_empty", {31'd0, out_valid}, 32'd0);
    phase_clr = 1'b0;
    freq_word = 24'h008000;
    #1;
    chk("clr_addr", {24'd0, rom_addr}, 32'd0);
    chk("clr_ce_n2", {31'd0, rom_ce_n}, 32'd0);
    step();
    chk("clr_lat_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("frac_half", {15'd0, out_valid, out_data}, {15'd0, smp(i / 2)});
    end

    // reset while the FIFO holds two samples
    out_ready = 1'b0;
    step();
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_ce_n",  {31'd0, rom_ce_n},  32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ce_n",  {31'd0, rom_ce_n},  32'd1);
    chk("mid_rst_addr",  {24'd0, rom_addr},  32'd0);
    freq_word = 24'hFF0000;
    out_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    step();
    chk("rr_lat_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_down", {15'd0, out_valid, out_data}, {15'd0, smp(256 - i)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sin_nco_rd.md
SIN_NCO_RD -- requirements
Module: sin_nco_rd

Interface
REQ-001 Parameter DW, default 16, ROM data width and output sample width.
REQ-002 Parameter AW, default 8, ROM address width.
REQ-003 Parameter PW, default 24, phase accumulator width; PW SHALL be >= AW.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  enable sample generation.
REQ-007 phase_clr  input  1  synchronous phase-accumulator clear.
REQ-008 freq_word  input  PW  phase increment per issued read.
REQ-009 rom_ce_n  output  1  ROM read strobe, active-low.
REQ-010 rom_addr  output  AW  ROM read address.
REQ-011 rom_data  input  DW  ROM read data; valid in the cycle after the edge that sampled rom_addr.
REQ-012 out_data  output  DW  sample at the FIFO head.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both 1 at posedge clk.

Function
REQ-015 The block SHALL hold a PW-bit phase register; rom_addr SHALL equal phase[PW-1:PW-AW] combinationally.
REQ-016 Definitions: issue = en & ~phase_clr & (count + inflight - pop < 2); pop = out_valid & out_ready; count = FIFO occupancy, 0..2; inflight = 1-bit register.
REQ-017 rom_ce_n SHALL equal ~issue; the combinational path from out_ready to rom_ce_n is permitted.
REQ-018 On an issue edge: phase <= phase + freq_word, modulo 2^PW with silent wrap; inflight <= 1.
REQ-019 On a non-issue edge: inflight <= 0 and phase is held, except as required by REQ-020.
REQ-020 phase_clr=1 SHALL set phase <= 0 and block issue in that cycle; an in-flight read SHALL still complete.
REQ-021 When inflight=1, rom_data SHALL be written into a 2-entry FIFO at the next edge; a read, once issued, SHALL never be dropped.
REQ-022 Latency: a read issued at edge N SHALL have its data visible on out_data, with out_valid=1, after edge N+1, provided the FIFO was empty.
REQ-023 A FIFO push and a pop in the same cycle SHALL leave count unchanged; order SHALL be strict FIFO.
REQ-024 out_valid SHALL equal (count != 0); out_data SHALL be the head entry; with out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-025 Throughput: with en=1 and out_ready held at 1, one sample SHALL be transferred per cycle in steady state.
REQ-026 freq_word SHALL be sampled on every issue edge; a change applies to the next issue.
REQ-027 When en falls: issuing SHALL stop that cycle; the in-flight read and the FIFO contents SHALL still drain.
REQ-028 FIFO overflow SHALL be impossible by construction of REQ-016; an assertion SHALL check count <= 2.

Reset
REQ-029 rst_n=0 SHALL immediately set phase=0, inflight=0, count=0, FIFO pointers=0, FIFO storage=0 and out_data=0.
REQ-030 While rst_n=0, the outputs SHALL be out_valid=0, rom_ce_n=1 and rom_addr=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight and buffered samples.
REQ-032 After rst_n rises, the first issue SHALL occur no earlier than the first posedge at which en=1.

Verification
REQ-033 Setup for all scenarios: PW=24, AW=8, DW=16, ROM model with mem[i]=16'h1000+i and a 1-cycle registered address.
REQ-034 Count-up: freq_word=24'h010000, en=1, out_ready=1 -> out_data 0x1000, 0x1001, 0x1002, ... one per cycle; the first out_valid appears 2 edges after en rises.
REQ-035 Wrap: freq_word=24'h010000, run 260 samples -> 0x10FF is followed by 0x1000, then 0x1001, with no gap.
REQ-036 Fractional step: freq_word=24'h008000 -> 0x1000, 0x1000, 0x1001, 0x1001, ...; freq_word=24'hFF0000 -> 0x1000, 0x10FF, 0x10FE, ...
REQ-037 Backpressure: out_ready=0 for 6 cycles mid-stream -> at most 2 samples buffered; rom_ce_n stays 1 once full; after release the sequence resumes with no loss or duplication.
REQ-038 en drop and clear: en=0 for one cycle, then phase_clr=1 for one cycle -> the in-flight sample is delivered; the next issued address is 0 (out_data 0x1000).
REQ-039 Reset mid-stream: rst_n=0 while count=2 -> out_valid=0 and rom_ce_n=1 immediately; after release with en=1 the stream restarts at 0x1000.
